// File: rtl/syn_sequencer_if.sv
// Synaptic sequencer bus: AER event handshake, SPI configuration handshake,
// synaptic SRAM control and status.
//   master : drives AER/SPI requests and the activity gate, observes the rest
//   slave  : the sequencer; acknowledges requests and drives SRAM control
interface syn_sequencer_if #(
    parameter int unsigned M = 8
);
    logic           SPI_GATE_ACTIVITY_sync;
    logic           AER_REQ;
    logic [M-1:0]   AER_ADDR;
    logic           AER_ACK;
    logic           SPI_SYN_REQ;
    logic           SPI_SYN_WR;
    logic [12:0]    SPI_SYN_ADDR;
    logic           SPI_SYN_ACK;
    logic           CTRL_SYNARRAY_CS;
    logic           CTRL_SYNARRAY_WE;
    logic [12:0]    CTRL_SYNARRAY_ADDR;
    logic [7:0]     CTRL_PRE_EN;
    logic           SEQ_BUSY;

    modport master (
        output SPI_GATE_ACTIVITY_sync, AER_REQ, AER_ADDR,
               SPI_SYN_REQ, SPI_SYN_WR, SPI_SYN_ADDR,
        input  AER_ACK, SPI_SYN_ACK, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
               CTRL_SYNARRAY_ADDR, CTRL_PRE_EN, SEQ_BUSY
    );

    modport slave (
        input  SPI_GATE_ACTIVITY_sync, AER_REQ, AER_ADDR,
               SPI_SYN_REQ, SPI_SYN_WR, SPI_SYN_ADDR,
        output AER_ACK, SPI_SYN_ACK, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
               CTRL_SYNARRAY_ADDR, CTRL_PRE_EN, SEQ_BUSY
    );
endinterface

// File: rtl/syn_sequencer.sv
// Synaptic SRAM sequencer. An accepted AER event walks the 32 words of the
// presynaptic neuron row with read/write pairs (SDSP update on the write);
// an SPI access does one read and an optional write-back at a given word.
// Ports:
//   CLK      : clock, rising edge
//   RST_sync : synchronous active-high reset
//   bus      : syn_sequencer_if.slave (requests in, acks/SRAM control out)
// Outputs are decoded from the state register and the registered address only.
module syn_sequencer #(
    parameter int unsigned N = 256,
    parameter int unsigned M = 8
) (
    input  logic            CLK,
    input  logic            RST_sync,
    syn_sequencer_if.slave  bus
);
    localparam int unsigned SRAM_AW = 13;
    localparam int unsigned WORD_W  = 5;
    localparam int unsigned PRE_W   = (M < $clog2(N)) ? M : $clog2(N);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(31);

    typedef enum logic [2:0] {
        IDLE, EV_RD, EV_WR, EV_ACK, SPI_RD, SPI_WR, SPI_ACK
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [PRE_W-1:0]     pre_addr_q, pre_addr_d;
    logic                 spi_wr_q, spi_wr_d;
    // SRAM address; carries the latched SPI address during SPI accesses and
    // holds its last value whenever the array is idle.
    logic [SRAM_AW-1:0]   addr_q, addr_d;

    logic                 cs_c, we_c, aer_ack_c, spi_ack_c;
    logic [7:0]           pre_en_c;
    logic [PRE_W-1:0]     aer_pre_c;

    assign aer_pre_c = PRE_W'(bus.AER_ADDR);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST_sync) begin
            state_q    <= IDLE;
            word_q     <= '0;
            pre_addr_q <= '0;
            spi_wr_q   <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            pre_addr_q <= pre_addr_d;
            spi_wr_q   <= spi_wr_d;
            addr_q     <= addr_d;
        end
    end

    // Next state, word counter and address
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        pre_addr_d = pre_addr_q;
        spi_wr_d   = spi_wr_q;
        addr_d     = addr_q;
        unique case (state_q)
            IDLE: begin
                // Gate high selects SPI and masks AER; AER_ACK is always low here
                if (bus.SPI_GATE_ACTIVITY_sync) begin
                    if (bus.SPI_SYN_REQ) begin
                        spi_wr_d = bus.SPI_SYN_WR;
                        addr_d   = bus.SPI_SYN_ADDR;
                        state_d  = SPI_RD;
                    end
                end else if (bus.AER_REQ) begin
                    pre_addr_d = aer_pre_c;
                    word_d     = '0;
                    addr_d     = SRAM_AW'({aer_pre_c, WORD_W'(0)});
                    state_d    = EV_RD;
                end
            end
            EV_RD:  state_d = EV_WR;
            EV_WR: begin
                if (word_q == WORD_LAST) begin
                    state_d = EV_ACK;
                end else begin
                    word_d  = word_q + WORD_W'(1);
                    addr_d  = SRAM_AW'({pre_addr_q, word_q + WORD_W'(1)});
                    state_d = EV_RD;
                end
            end
            EV_ACK:  if (!bus.AER_REQ) state_d = IDLE;
            SPI_RD:  state_d = spi_wr_q ? SPI_WR : SPI_ACK;
            SPI_WR:  state_d = SPI_ACK;
            SPI_ACK: if (!bus.SPI_SYN_REQ) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        cs_c      = 1'b0;
        we_c      = 1'b0;
        pre_en_c  = 8'h00;
        aer_ack_c = 1'b0;
        spi_ack_c = 1'b0;
        unique case (state_q)
            EV_RD:   cs_c = 1'b1;
            EV_WR: begin
                cs_c     = 1'b1;
                we_c     = 1'b1;
                pre_en_c = 8'hFF;
            end
            EV_ACK:  aer_ack_c = 1'b1;
            SPI_RD:  cs_c = 1'b1;
            SPI_WR: begin
                cs_c = 1'b1;
                we_c = 1'b1;
            end
            SPI_ACK: spi_ack_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.CTRL_SYNARRAY_CS   = cs_c;
    assign bus.CTRL_SYNARRAY_WE   = we_c;
    assign bus.CTRL_SYNARRAY_ADDR = addr_q;
    assign bus.CTRL_PRE_EN        = pre_en_c;
    assign bus.AER_ACK            = aer_ack_c;
    assign bus.SPI_SYN_ACK        = spi_ack_c;
    assign bus.SEQ_BUSY           = (state_q != IDLE);
endmodule

// File: doc/syn_sequencer.md
SYN_SEQUENCER -- requirements
Module: syn_sequencer

Interface
REQ-001 Parameter N, default 256, number of neurons (pre- and post-synaptic).
REQ-002 Parameter M, default 8, log2(N), the neuron address width.
REQ-003 The module SHALL have exactly one clock, CLK; its reset SHALL be synchronous and active-high, named RST_sync.
REQ-004 Ports SHALL be:
- CLK  in  1  clock, all logic on rising edge.
- RST_sync  in  1  synchronous active-high reset.
- SPI_GATE_ACTIVITY_sync  in  1  configuration mode; blocks new AER events.
- AER_REQ  in  1  presynaptic event request, 4-phase level.
- AER_ADDR  in  M  presynaptic neuron address.
- AER_ACK  out  1  event acknowledge.
- SPI_SYN_REQ  in  1  configuration access request, 4-phase level.
- SPI_SYN_WR  in  1  1 = read-modify-write, 0 = read only.
- SPI_SYN_ADDR  in  13  synaptic word address.
- SPI_SYN_ACK  out  1  configuration access acknowledge.
- CTRL_SYNARRAY_CS  out  1  synaptic SRAM chip select (active high).
- CTRL_SYNARRAY_WE  out  1  synaptic SRAM write enable (active high).
- CTRL_SYNARRAY_ADDR  out  13  synaptic SRAM word address.
- CTRL_PRE_EN  out  8  per-synapse SDSP update enable for the current word.
- SEQ_BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-005 The module SHALL implement a state machine with states IDLE, EV_RD, EV_WR, EV_ACK, SPI_RD, SPI_WR and SPI_ACK, held in a state register.
REQ-006 All outputs SHALL be decoded from registered state, word counter and latched address only, with no combinational path from any input to any output.
REQ-007 IDLE, AER accept: when SPI_GATE_ACTIVITY_sync=0, AER_REQ=1 and AER_ACK=0, the module SHALL latch AER_ADDR into pre_addr, clear the 5-bit word counter and go to EV_RD.
REQ-008 IDLE, SPI accept: when SPI_GATE_ACTIVITY_sync=1 and SPI_SYN_REQ=1, the module SHALL latch SPI_SYN_ADDR and SPI_SYN_WR and go to SPI_RD.
REQ-009 IDLE, priority: if both accept conditions could apply, SPI SHALL win; AER_REQ SHALL be ignored while SPI_GATE_ACTIVITY_sync=1.
REQ-010 EV_RD: CS=1, WE=0, ADDR={pre_addr, word}, PRE_EN=0; next state EV_WR.
REQ-011 EV_WR: CS=1, WE=1, ADDR unchanged from EV_RD, PRE_EN=8'hFF; the SRAM read data is valid this cycle, so the SDSP write data is formed from it.
REQ-012 EV_WR exit: if word=31, next state SHALL be EV_ACK; otherwise word SHALL increment by 1 and next state SHALL be EV_RD. The counter SHALL never wrap inside one event.
REQ-013 EV_ACK: AER_ACK=1, CS=0; the module SHALL stay in EV_ACK until AER_REQ=0, then go to IDLE with AER_ACK=0 in the IDLE cycle.
REQ-014 Event timing: exactly 64 SRAM accesses, alternating read/write, on addresses {pre_addr,0} through {pre_addr,31}; AER_ACK SHALL rise 65 cycles after the accept edge.
REQ-015 SPI_RD: CS=1, WE=0, ADDR=latched SPI address, PRE_EN=0; next state SPI_WR if the latched WR bit is 1, else SPI_ACK.
REQ-016 SPI_WR: CS=1, WE=1, same ADDR, PRE_EN=0; next state SPI_ACK.
REQ-017 SPI_ACK: SPI_SYN_ACK=1, CS=0; the module SHALL stay in SPI_ACK until SPI_SYN_REQ=0, then go to IDLE.
REQ-018 Gate changes mid-operation: a change of SPI_GATE_ACTIVITY_sync during an event or SPI access SHALL NOT abort it; the operation SHALL complete.
REQ-019 Outside EV_RD, EV_WR, SPI_RD and SPI_WR, CS, WE and PRE_EN SHALL be 0 and ADDR SHALL hold its last value.
REQ-020 Request changes: AER_ADDR and SPI_SYN_ADDR changes after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-021 On RST_sync=1 at a clock edge, regardless of state, the module SHALL enter IDLE with word=0, pre_addr=0, latched SPI address=0 and WR bit=0.
REQ-022 Output reset values SHALL be CS=0, WE=0, ADDR=0, PRE_EN=0, AER_ACK=0, SPI_SYN_ACK=0, SEQ_BUSY=0.
REQ-023 A reset during EV_WR or SPI_WR SHALL prevent any further SRAM access after the reset edge.

Verification
REQ-024 AER event: gate=0, AER_ADDR=8'h5A, AER_REQ=1 -> 64 accesses at 0x0B40..0x0B5F, R/W alternating, PRE_EN=8'hFF on writes only; AER_ACK rises on cycle 65; AER_REQ drop -> ACK=0 the next cycle.
REQ-025 SPI write: gate=1, SPI_SYN_ADDR=0x1234, WR=1, REQ=1 -> one read then one write at 0x1234 with PRE_EN=0, then SPI_SYN_ACK=1; no AER_ACK while a concurrent AER_REQ is held.
REQ-026 SPI read only: WR=0, SPI_SYN_ADDR=0x0007 -> a single read cycle at 0x0007, no WE pulse, ACK on the following cycle.
REQ-027 Gate raised at word 10 of an event -> the event finishes all 32 words and acknowledges; the next AER_REQ is blocked until gate=0.
REQ-028 RST_sync pulsed at word 17 in EV_WR -> IDLE and all outputs 0 from the next cycle, no further SRAM access; a new event then restarts at word 0.
